// File: rtl/mem_copy_dma_if.sv
// Bus bundle between the copy engine and its environment (requester +
// 16-bit word memory).
//   start/srcAddr/dstAddr/len : copy request
//   rdyMem/memRdata           : memory ready flag and read data
//   addrBus/readMem/writeMem/wdata : memory access
//   busy/done/error           : status
// Modport master is the engine side; slave is the requester/memory side.
interface mem_copy_dma_if;
  logic        start;
  logic [7:0]  srcAddr;
  logic [7:0]  dstAddr;
  logic [7:0]  len;
  logic        rdyMem;
  logic [15:0] memRdata;
  logic [7:0]  addrBus;
  logic        readMem;
  logic        writeMem;
  logic [15:0] wdata;
  logic        busy;
  logic        done;
  logic        error;

  modport master (
    input  start, srcAddr, dstAddr, len, rdyMem, memRdata,
    output addrBus, readMem, writeMem, wdata, busy, done, error
  );

  modport slave (
    output start, srcAddr, dstAddr, len, rdyMem, memRdata,
    input  addrBus, readMem, writeMem, wdata, busy, done, error
  );
endinterface

// File: rtl/mem_copy_dma.sv
// Word-by-word memory copy engine. Copies len words from srcAddr.. to
// dstAddr.. in ascending order, one RD/WR/GAP triple per word, with a
// read-wait timeout that raises a sticky error.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : mem_copy_dma_if.master (request, memory port, status)
module mem_copy_dma #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  mem_copy_dma_if.master    bus
);

  typedef enum logic [2:0] {IDLE, RD, WR, GAP, FIN, ERR} state_e;

  state_e      state_q, state_d;
  logic [7:0]  src_q, src_d;
  logic [7:0]  dst_q, dst_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  wait_q, wait_d;
  logic [15:0] wdata_q, wdata_d;
  logic [7:0]  addr_q, addr_d;
  logic        err_q, err_d;

  logic [7:0]  rd_addr, wr_addr, addr_out;

  // Carry out of the 8-bit sums is dropped: addresses wrap modulo 256.
  assign rd_addr = src_q + idx_q;
  assign wr_addr = dst_q + idx_q;

  // addrBus follows the active access and otherwise holds the last value.
  always_comb begin
    addr_out = addr_q;
    if (state_q == RD) addr_out = rd_addr;
    if (state_q == WR) addr_out = wr_addr;
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    idx_d   = idx_q;
    wait_d  = wait_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    addr_d  = addr_out;
    case (state_q)
      IDLE: if (bus.start) begin
        src_d   = bus.srcAddr;
        dst_d   = bus.dstAddr;
        len_d   = bus.len;
        idx_d   = 8'd0;
        wait_d  = 8'd0;
        err_d   = 1'b0;
        state_d = (bus.len != 8'd0) ? RD : FIN;
      end
      RD: begin
        if (bus.rdyMem) begin
          wdata_d = bus.memRdata;
          wait_d  = 8'd0;
          state_d = WR;
        end else if (({1'b0, wait_q} + 9'd1) >= 9'(TIMEOUT)) begin
          // This was the TIMEOUT-th RD cycle without ready.
          wait_d  = 8'd0;
          err_d   = 1'b1;
          state_d = ERR;
        end else begin
          wait_d  = wait_q + 8'd1;
        end
      end
      WR: begin
        if (idx_q == len_q - 8'd1) begin
          state_d = FIN;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = GAP;
        end
      end
      GAP:     state_d = RD;
      FIN:     state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      src_q   <= 8'd0;
      dst_q   <= 8'd0;
      len_q   <= 8'd0;
      idx_q   <= 8'd0;
      wait_q  <= 8'd0;
      wdata_q <= 16'd0;
      addr_q  <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      wait_q  <= wait_d;
      wdata_q <= wdata_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
    end
  end

  // Strobes decode straight from the state register, so reset clears them
  // in the same instant it forces IDLE.
  assign bus.addrBus  = addr_out;
  assign bus.readMem  = (state_q == RD);
  assign bus.writeMem = (state_q == WR);
  assign bus.wdata    = wdata_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = (state_q == FIN);
  assign bus.error    = err_q;

endmodule

// File: tb/tb_mem_copy_dma.sv
module tb_mem_copy_dma;
  localparam int TO = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_copy_dma_if bus();
  mem_copy_dma #(.TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Word memory: fill pattern, directed preload, DUT writes.
  logic [15:0] mem [256];
  logic        fill, pl_we, rdy_mode;
  logic [7:0]  pl_a;
  logic [15:0] pl_d;
  int          wr_cnt = 0;

  assign bus.memRdata = mem[bus.addrBus];
  assign bus.rdyMem   = rdy_mode;

  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'(i * 16'h0101) ^ 16'h3C00;
    end else if (pl_we) begin
      mem[pl_a] <= pl_d;
    end else if (bus.writeMem) begin
      mem[bus.addrBus] <= bus.wdata;
      wr_cnt <= wr_cnt + 1;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic        rd, wr, busy, done, err;
    logic [7:0]  addr;
    logic [15:0] wd;
    logic        chk_wd;
  } exp_t;

  exp_t        q[$];
  logic [15:0] mm [256];
  logic        idle_err = 1'b0, nx_err = 1'b0;
  logic [7:0]  idle_addr = 8'd0, nx_addr = 8'd0;

  function automatic exp_t mk(logic rd, logic wr, logic b, logic d, logic e,
                              logic [7:0] a, logic [15:0] wd, logic c);
    exp_t r;
    r = '{rd: rd, wr: wr, busy: b, done: d, err: e, addr: a, wd: wd, chk_wd: c};
    return r;
  endfunction

  // Expected per-cycle trace of one accepted copy, starting the cycle after
  // the accepting edge.
  task automatic gen(input logic [7:0] s, input logic [7:0] d, input logic [7:0] n);
    logic [7:0]  ra, wa;
    logic [15:0] v;
    if (n == 8'd0) begin
      q.push_back(mk(0, 0, 1, 1, 0, idle_addr, 16'd0, 0));
      nx_err = 1'b0; nx_addr = idle_addr;
    end else if (!rdy_mode) begin
      for (int t = 0; t < TO; t++) q.push_back(mk(1, 0, 1, 0, 0, s, 16'd0, 0));
      q.push_back(mk(0, 0, 1, 0, 1, s, 16'd0, 0));
      nx_err = 1'b1; nx_addr = s;
    end else begin
      wa = d;
      for (int w = 0; w < int'(n); w++) begin
        ra = 8'(int'(s) + w);
        wa = 8'(int'(d) + w);
        v  = mm[ra];
        mm[wa] = v;
        q.push_back(mk(1, 0, 1, 0, 0, ra, 16'd0, 0));
        q.push_back(mk(0, 1, 1, 0, 0, wa, v, 1));
        if (w < int'(n) - 1) q.push_back(mk(0, 0, 1, 0, 0, wa, 16'd0, 0));
      end
      q.push_back(mk(0, 0, 1, 1, 0, wa, 16'd0, 0));
      nx_err = 1'b0; nx_addr = wa;
    end
  endtask

  always @(negedge clk) begin
    exp_t e, a;
    if (rst) begin
      q.delete();
      idle_err = 1'b0; idle_addr = 8'd0;
      e = mk(0, 0, 0, 0, 0, 8'd0, 16'd0, 1);
    end else if (q.size() == 0) begin
      e = mk(0, 0, 0, 0, idle_err, idle_addr, 16'd0, 0);
      for (int i = 0; i < 256; i++) mm[i] = mem[i];
      if (bus.start) gen(bus.srcAddr, bus.dstAddr, bus.len);
    end else begin
      e = q.pop_front();
      if (q.size() == 0) begin idle_err = nx_err; idle_addr = nx_addr; end
    end
    a = mk(bus.readMem, bus.writeMem, bus.busy, bus.done, bus.error, bus.addrBus,
           e.chk_wd ? bus.wdata : e.wd, e.chk_wd);
    chk("cycle{rd,wr,busy,done,err,addr,wdata}", 64'(a), 64'(e));
  end

  // ---------------- directed stimulus ----------------
  // Returns the cycle index (0 = cycle right after the start edge) of the
  // done pulse, or -1 if none appears within budget.
  task automatic do_copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] n,
                         input int budget, output int dc);
    bus.srcAddr = s; bus.dstAddr = d; bus.len = n;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    dc = -1;
    for (int k = 0; k < budget; k++) begin
      if (bus.done) begin dc = k; break; end
      @(posedge clk); #1;
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [15:0] v);
    pl_a = a; pl_d = v; pl_we = 1'b1;
    @(posedge clk); #1;
    pl_we = 1'b0;
  endtask

  initial begin
    int dc, base, dones;
    rst = 1'b1; fill = 1'b1; pl_we = 1'b0; pl_a = 8'd0; pl_d = 16'd0; rdy_mode = 1'b1;
    bus.start = 1'b0; bus.srcAddr = 8'd0; bus.dstAddr = 8'd0; bus.len = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset outputs", {bus.readMem, bus.writeMem, bus.busy, bus.done, bus.error, bus.addrBus, bus.wdata}, 64'd0);
    fill = 1'b0;
    rst  = 1'b0;
    preload(8'h10, 16'hAAAA);
    preload(8'h11, 16'hBBBB);
    preload(8'h12, 16'hCCCC);
    repeat (2) @(posedge clk);
    #1;

    // Basic 3-word copy.
    base = wr_cnt;
    do_copy(8'h10, 8'h40, 8'd3, 60, dc);
    chk("len3 done cycle", 64'(dc), 64'd8);
    chk("len3 writes", 64'(wr_cnt - base), 64'd3);
    chk("mem40", 64'(mem[8'h40]), 64'hAAAA);
    chk("mem41", 64'(mem[8'h41]), 64'hBBBB);
    chk("mem42", 64'(mem[8'h42]), 64'hCCCC);

    // Zero length.
    base = wr_cnt;
    do_copy(8'h20, 8'h50, 8'd0, 20, dc);
    chk("len0 done cycle", 64'(dc), 64'd0);
    chk("len0 writes", 64'(wr_cnt - base), 64'd0);

    // Wrap with overlapping regions: the first word ripples forward.
    base = wr_cnt;
    do_copy(8'hFE, 8'hFF, 8'd3, 60, dc);
    chk("wrap done cycle", 64'(dc), 64'd8);
    chk("memFF", 64'(mem[8'hFF]), 64'hC2FE);
    chk("mem00", 64'(mem[8'h00]), 64'hC2FE);
    chk("mem01", 64'(mem[8'h01]), 64'hC2FE);

    // Read timeout.
    rdy_mode = 1'b0;
    base = wr_cnt;
    do_copy(8'h30, 8'h60, 8'd2, 40, dc);
    chk("timeout no done", 64'(dc), 64'hFFFF_FFFF_FFFF_FFFF);
    chk("timeout error", 64'(bus.error), 64'd1);
    chk("timeout busy", 64'(bus.busy), 64'd0);
    chk("timeout writes", 64'(wr_cnt - base), 64'd0);
    rdy_mode = 1'b1;
    do_copy(8'h10, 8'h70, 8'd1, 20, dc);
    chk("restart done cycle", 64'(dc), 64'd2);
    chk("restart clears error", 64'(bus.error), 64'd0);
    chk("mem70", 64'(mem[8'h70]), 64'hAAAA);

    // Reset in the second WR of a 4-word copy.
    base = wr_cnt;
    bus.srcAddr = 8'h10; bus.dstAddr = 8'h80; bus.len = 8'd4;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("second WR active", 64'({bus.writeMem, bus.addrBus}), 64'h181);
    #1 rst = 1'b1;
    #1;
    chk("rst immediate outputs", {bus.readMem, bus.writeMem, bus.busy, bus.done, bus.error, bus.addrBus, bus.wdata}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("rst abort writes", 64'(wr_cnt - base), 64'd1);
    chk("mem80", 64'(mem[8'h80]), 64'hAAAA);
    chk("mem81 untouched", 64'(mem[8'h81]), 64'hBD81);
    chk("busy low after rst", 64'(bus.busy), 64'd0);

    // start held high: one transfer per IDLE visit.
    base = wr_cnt; dones = 0;
    bus.srcAddr = 8'h11; bus.dstAddr = 8'h90; bus.len = 8'd1;
    bus.start = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(posedge clk); #1;
      if (bus.done) dones++;
    end
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("held start dones", 64'(dones), 64'd2);
    chk("held start writes", 64'(wr_cnt - base), 64'd2);

    // start pulse while busy is ignored.
    base = wr_cnt; dones = 0;
    bus.srcAddr = 8'h10; bus.dstAddr = 8'hA0; bus.len = 8'd3;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (bus.done) dones++;
      bus.start = (k == 3);
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    chk("busy pulse dones", 64'(dones), 64'd1);
    chk("busy pulse writes", 64'(wr_cnt - base), 64'd3);
    chk("memA2", 64'(mem[8'hA2]), 64'hCCCC);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_copy_dma.md
MEM_COPY_DMA -- requirements
Module: mem_copy_dma

Interface
REQ-001 Parameter TIMEOUT, default 15, maximum read-wait cycles before an error is raised (range 1..255).
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request a copy; sampled only in IDLE.
REQ-005 srcAddr  input  8  first source word address; captured on accepted start.
REQ-006 dstAddr  input  8  first destination word address; captured on accepted start.
REQ-007 len  input  8  number of words to copy (0..255); captured on accepted start.
REQ-008 rdyMem  input  1  memory ready flag from the 16-bit word memory.
REQ-009 memRdata  input  16  memory read bus (outBus of the memory).
REQ-010 addrBus  output  8  memory word address.
REQ-011 readMem  output  1  memory read request.
REQ-012 writeMem  output  1  memory write strobe; memory writes on the rising clk edge while high.
REQ-013 wdata  output  16  memory write data (drives memory inBus).
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse on successful completion.
REQ-016 error  output  1  sticky read-timeout flag; cleared by the next accepted start or by rst.

Function
REQ-017 States SHALL be IDLE, RD, WR, GAP, FIN, ERR; encoding is free.
REQ-018 IDLE: start=1 -> latch srcAddr/dstAddr/len, idx=0, clear error; next RD if len!=0, else FIN.
REQ-019 IDLE with start=0 SHALL remain in IDLE; start while not in IDLE SHALL be ignored.
REQ-020 RD: readMem=1, writeMem=0, addrBus=(src+idx) mod 256; wait counter increments each RD cycle.
REQ-021 RD: rdyMem=1 sampled at end of an RD cycle -> wdata<=memRdata, go WR, clear wait counter.
REQ-022 RD: wait counter reaching TIMEOUT with rdyMem=0 -> ERR; the counter starts at 0 on every RD entry.
REQ-023 WR: writeMem=1 for exactly one cycle, readMem=0, addrBus=(dst+idx) mod 256, wdata held stable.
REQ-024 WR -> FIN if idx==len-1, else idx<=idx+1 and -> GAP.
REQ-025 GAP: readMem=0, writeMem=0 for one cycle (guarantees a fresh readMem rising edge), then -> RD.
REQ-026 Steady-state throughput SHALL be 3 cycles per word with immediate rdyMem; len=N completes N*3-1 cycles after the start edge, plus 1 cycle for FIN.
REQ-027 FIN: done=1 for one cycle, then -> IDLE; len=0 gives done on the cycle after start.
REQ-028 ERR: error=1, busy=1 for one cycle, then -> IDLE with error held high; no further memory writes.
REQ-029 Address arithmetic SHALL wrap modulo 256 (src+idx and dst+idx carry discarded).
REQ-030 readMem and writeMem SHALL never be high in the same cycle.
REQ-031 Overlapping regions SHALL be copied in ascending index order, with no overlap correction.
REQ-032 addrBus SHALL hold its last value in IDLE; wdata SHALL change only on RD capture.

Reset
REQ-033 rst=1 SHALL immediately force IDLE and clear readMem, writeMem, busy, done, error, idx, the wait counter, addrBus=0 and wdata=0.
REQ-034 rst asserted mid-transfer SHALL abort the transfer; no write strobe is issued after rst asserts; operation resumes only after a new start.

Verification
REQ-035 Preload mem[0x10..0x12]=A,B,C; start src=0x10 dst=0x40 len=3 -> mem[0x40..0x42]=A,B,C, three one-cycle writeMem pulses, done 9 cycles after the start edge.
REQ-036 start len=0 -> no readMem/writeMem activity, done pulse on next cycle, busy high for 1 cycle.
REQ-037 src=0xFE dst=0xFF len=3 -> reads 0xFE,0xFF,0x00; writes 0xFF,0x00,0x01 (wrap).
REQ-038 Memory model holds rdyMem=0 -> error=1 after TIMEOUT RD cycles, zero writes, return to IDLE; a subsequent start clears error.
REQ-039 rst pulse during the second WR of a len=4 copy -> outputs zero immediately, only 1-2 destination words written, busy stays low until a new start.
REQ-040 start held high through a whole transfer -> exactly one transfer per IDLE visit; a pulse while busy has no effect.
